irq_ctrl: RTL and testbench
===========================

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter N_IRQ, default 5: number of interrupt sources, legal range 1..8.
REQ-002 Parameter IE_ADDR, default 16'hFFFF: enable register address.
REQ-003 Parameter IF_ADDR, default 16'hFF0F: flag register address.
REQ-004 Parameter EDGE_MASK, default all ones (N_IRQ bits): bit=1 means source is rising-edge triggered; bit=0 means level triggered.
REQ-005 Parameter VEC_BASE, default 16'h0040: vector of source 0.
REQ-006 Parameter VEC_STRIDE, default 8: vector spacing per source.
REQ-007 clk  in  1  single clock; all state on rising edge.
REQ-008 rst  in  1  asynchronous, active-low reset.
REQ-009 a  in  16  CPU address.
REQ-010 din  in  8  CPU write data.
REQ-011 rd  in  1  CPU read strobe.
REQ-012 wr  in  1  CPU write strobe.
REQ-013 dout  out  8  read data, combinational.
REQ-014 sel  out  1  combinational; high when a==IE_ADDR or a==IF_ADDR.
REQ-015 int_req  in  N_IRQ  peripheral requests, synchronous to clk.
REQ-016 ime  in  1  CPU master interrupt enable.
REQ-017 irq  out  1  interrupt request to CPU.
REQ-018 ack  in  1  CPU acknowledge, single-cycle pulse.
REQ-019 vec  out  16  service vector.
REQ-020 vec_valid  out  1  vec valid, one-cycle pulse.
REQ-021 wake  out  1  HALT wake-up, ignores ime.
REQ-022 pending  out  N_IRQ  current IF register contents.

Function
REQ-023 Registers: IE[N_IRQ-1:0], IF[N_IRQ-1:0], req_d[N_IRQ-1:0] (previous int_req), FSM state, vector index.
REQ-024 set[i] = EDGE_MASK[i] ? (int_req[i] & ~req_d[i]) : int_req[i].
REQ-025 Write to IE_ADDR with wr: IE <= din[N_IRQ-1:0], visible next cycle.
REQ-026 Write to IF_ADDR with wr: IF <= din[N_IRQ-1:0] | set.
REQ-027 No IF write: IF <= (IF & ~clr) | set; clr is the one-hot grant bit from REQ-031, else 0.
REQ-028 Same-bit set and clr (or set and written 0) in one cycle: set wins; bit reads 1 next cycle.
REQ-029 Reads (rd high, address match): IF_ADDR returns IF in low bits with unused bits as 1; IE_ADDR returns IE in low bits with unused bits as 0; otherwise dout=8'h00.
REQ-030 en = IE & IF; wake = |en, combinational.
REQ-031 FSM states IDLE, PEND, GRANT.
- IDLE: irq=0; goes to PEND when ime & |en.
- PEND: irq=1; ime low or en==0 returns to IDLE with no vector.
- PEND with ack: latch idx = lowest set bit of en (source 0 highest priority), assert clr for idx this cycle, go to GRANT.
REQ-032 ack in PEND with en==0 in the same cycle: vec=16'h0000, no IF bit cleared, still go to GRANT.
REQ-033 GRANT: irq=0 and vec_valid=1 for exactly one cycle, then IDLE; ack in IDLE or GRANT is ignored.
REQ-034 vec = VEC_BASE + idx*VEC_STRIDE, truncated to 16 bits; held stable until the next grant.
REQ-035 Grant latency: ack in PEND at cycle n gives vec_valid and updated IF at cycle n+1.
REQ-036 Re-entry: IDLE may return to PEND no earlier than the cycle after GRANT.

Reset
REQ-037 rst low asynchronously sets IE=0, IF=0, req_d=0, state=IDLE, vec=0, irq=0, vec_valid=0; wake=0 follows.
REQ-038 rst low mid-grant abandons the grant; no vec_valid pulse is produced after release.
REQ-039 First edge detection after release compares against req_d=0, so a request held high through reset sets IF once on release.

Verification
REQ-040 Defaults. Write IE=8'h1F; ime=1; pulse int_req=5'b00100 for 1 cycle -> IF=5'b00100, irq=1; ack -> next cycle vec=16'h0050, vec_valid=1, IF=0.
REQ-041 Priority. IF=5'b10010, IE=8'h1F, ack -> vec=16'h0048, IF=5'b10000; second ack -> vec=16'h0060.
REQ-042 Edge vs level. EDGE_MASK=5'b11110; hold int_req[0] high, clear IF via write -> IF[0] reads 1 next cycle; hold int_req[1] high, clear IF -> IF[1] stays 0.
REQ-043 Collision and cancel.
- IF write 8'h00 in the same cycle as an int_req[3] edge -> IF=5'b01000.
- IF cleared in the same cycle as ack -> vec=16'h0000.
REQ-044 Reads, wake and reset.
- Read IF with IF=5'b00001 -> dout=8'hE1.
- ime=0 with enabled pending -> wake=1, irq=0.
- rst low in GRANT -> all outputs 0 immediately.
REQ-045 Parametrised build. N_IRQ=8, VEC_BASE=16'hFFF8, VEC_STRIDE=4, grant idx 3 -> vec=16'h0004 (wrap).

Source files
------------

// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : irq_ctrl
//  Description : Interrupt controller with an enable register (IE) and a flag
//                register (IF), both CPU-accessible, per-source edge or level
//                triggering, fixed priority (source 0 highest), and a vectored
//                grant handshake.
//  Ports       : clk, rst (async, active low)
//                a/din/rd/wr  -> CPU register port, dout/sel combinational
//                int_req      -> peripheral requests (synchronous to clk)
//                ime/irq/ack  -> CPU interrupt handshake
//                vec/vec_valid-> service vector, one-cycle valid pulse
//                wake         -> HALT wake-up (ignores ime)
//                pending      -> current IF contents
//  Revision    : 1.0  initial release
// ============================================================================
module irq_ctrl #(
  parameter int unsigned        N_IRQ      = 5,
  parameter logic [15:0]        IE_ADDR    = 16'hFFFF,
  parameter logic [15:0]        IF_ADDR    = 16'hFF0F,
  parameter logic [N_IRQ-1:0]   EDGE_MASK  = {N_IRQ{1'b1}},
  parameter logic [15:0]        VEC_BASE   = 16'h0040,
  parameter int unsigned        VEC_STRIDE = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       a,
  input  logic [7:0]        din,
  input  logic              rd,
  input  logic              wr,
  output logic [7:0]        dout,
  output logic              sel,
  input  logic [N_IRQ-1:0]  int_req,
  input  logic              ime,
  output logic              irq,
  input  logic              ack,
  output logic [15:0]       vec,
  output logic              vec_valid,
  output logic              wake,
  output logic [N_IRQ-1:0]  pending
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_GRANT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [N_IRQ-1:0]  ie_q, ie_d;
  logic [N_IRQ-1:0]  if_q, if_d;
  logic [N_IRQ-1:0]  req_prev_q, req_prev_d;
  logic [15:0]       vec_q, vec_d;
  logic              irq_q, irq_d;
  logic              vec_valid_q, vec_valid_d;

  logic [N_IRQ-1:0]  set_bits;
  logic [N_IRQ-1:0]  clr_bits;
  logic [N_IRQ-1:0]  en;
  logic [N_IRQ-1:0]  grant_oh;
  logic [2:0]        grant_idx;
  logic [15:0]       vec_calc;
  logic              ie_hit;
  logic              if_hit;

  // Only din[N_IRQ-1:0] carries register data; the rest is ignored on purpose.
  logic              unused_din;
  assign unused_din = ^din;

  assign ie_hit  = (a == IE_ADDR);
  assign if_hit  = (a == IF_ADDR);
  assign sel     = ie_hit | if_hit;
  assign en      = ie_q & if_q;
  assign wake    = |en;
  assign pending = if_q;
  assign irq       = irq_q;
  assign vec       = vec_q;
  assign vec_valid = vec_valid_q;

  // Edge sources fire on a 0->1 transition against last cycle's sample;
  // level sources fire every cycle the request is high.
  assign set_bits = (EDGE_MASK & int_req & ~req_prev_q) | (~EDGE_MASK & int_req);

  // Priority pick: scan from the top down so the lowest set bit wins.
  always_comb begin
    grant_idx = 3'd0;
    grant_oh  = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (en[i]) begin
        grant_idx   = 3'(i);
        grant_oh    = '0;
        grant_oh[i] = 1'b1;
      end
    end
  end

  assign vec_calc = VEC_BASE + (16'(grant_idx) * 16'(VEC_STRIDE));

  // Grant FSM next-state and vector capture.
  always_comb begin
    state_d  = state_q;
    clr_bits = '0;
    vec_d    = vec_q;
    case (state_q)
      ST_IDLE: begin
        if (ime && (|en)) state_d = ST_PEND;
      end
      ST_PEND: begin
        // An ack always completes the handshake, even if the source vanished
        // in the meantime; in that case a null vector is handed out.
        if (ack) begin
          state_d = ST_GRANT;
          if (|en) begin
            clr_bits = grant_oh;
            vec_d    = vec_calc;
          end else begin
            vec_d    = 16'h0000;
          end
        end else if (!ime || (en == '0)) begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    irq_d       = (state_d == ST_PEND);
    vec_valid_d = (state_d == ST_GRANT);
  end

  // Register file updates; set_bits is OR-ed last so a new request beats
  // both a grant clear and a CPU write of 0 to the same bit.
  always_comb begin
    req_prev_d = int_req;
    ie_d       = ie_q;
    if (wr && ie_hit) ie_d = din[N_IRQ-1:0];
    if (wr && if_hit) if_d = din[N_IRQ-1:0] | set_bits;
    else              if_d = (if_q & ~clr_bits) | set_bits;
  end

  // Read mux: unused IF bits read as 1, unused IE bits read as 0.
  always_comb begin
    dout = 8'h00;
    if (rd && if_hit) begin
      dout             = 8'hFF;
      dout[N_IRQ-1:0]  = if_q;
    end else if (rd && ie_hit) begin
      dout             = 8'h00;
      dout[N_IRQ-1:0]  = ie_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      ie_q        <= '0;
      if_q        <= '0;
      req_prev_q  <= '0;
      vec_q       <= 16'h0000;
      irq_q       <= 1'b0;
      vec_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ie_q        <= ie_d;
      if_q        <= if_d;
      req_prev_q  <= req_prev_d;
      vec_q       <= vec_d;
      irq_q       <= irq_d;
      vec_valid_q <= vec_valid_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_irq_ctrl
//  Description : Self-checking bench for irq_ctrl. Three instances: defaults,
//                mixed edge/level sources, and an 8-source build with a
//                wrapping vector. Expected vectors are queued by the stimulus
//                and consumed by monitors on each vec_valid pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_irq_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] a;
  logic [7:0]  din;
  logic        rd;
  logic        wr;
  logic [7:0]  req;
  logic        ime0, ack0, ime1, ack1, ime2, ack2;

  logic [7:0]  dout0, dout1, dout2;
  logic        sel0, sel1, sel2;
  logic        irq0, irq1, irq2;
  logic [15:0] vec0, vec1, vec2;
  logic        vv0, vv1, vv2;
  logic        wake0, wake1, wake2;
  logic [4:0]  pend0, pend1;
  logic [7:0]  pend2;

  int checks;
  int failures;
  logic [15:0] q0[$];
  logic [15:0] q2[$];

  localparam logic [15:0] IE_A = 16'hFFFF;
  localparam logic [15:0] IF_A = 16'hFF0F;

  irq_ctrl dut0 (
    .clk(clk), .rst(rst), .a(a), .din(din), .rd(rd), .wr(wr),
    .dout(dout0), .sel(sel0), .int_req(req[4:0]), .ime(ime0), .irq(irq0),
    .ack(ack0), .vec(vec0), .vec_valid(vv0), .wake(wake0), .pending(pend0)
  );

  irq_ctrl #(.EDGE_MASK(5'b11110)) dut1 (
    .clk(clk), .rst(rst), .a(a), .din(din), .rd(rd), .wr(wr),
    .dout(dout1), .sel(sel1), .int_req(req[4:0]), .ime(ime1), .irq(irq1),
    .ack(ack1), .vec(vec1), .vec_valid(vv1), .wake(wake1), .pending(pend1)
  );

  irq_ctrl #(.N_IRQ(8), .EDGE_MASK(8'hFF), .VEC_BASE(16'hFFF8), .VEC_STRIDE(4)) dut2 (
    .clk(clk), .rst(rst), .a(a), .din(din), .rd(rd), .wr(wr),
    .dout(dout2), .sel(sel2), .int_req(req), .ime(ime2), .irq(irq2),
    .ack(ack2), .vec(vec2), .vec_valid(vv2), .wake(wake2), .pending(pend2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [15:0] addr, input logic [7:0] data);
    a   = addr;
    din = data;
    wr  = 1'b1;
    step();
    wr  = 1'b0;
  endtask

  task automatic mon0();
    forever begin
      @(negedge clk);
      if (rst && vv0) begin
        if (q0.size() == 0) chk("dut0_unexpected_vec_valid", 16'd1, 16'd0);
        else                chk("dut0_vec", vec0, q0.pop_front());
      end
    end
  endtask

  task automatic mon2();
    forever begin
      @(negedge clk);
      if (rst && vv2) begin
        if (q2.size() == 0) chk("dut2_unexpected_vec_valid", 16'd1, 16'd0);
        else                chk("dut2_vec", vec2, q2.pop_front());
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0; a = 16'h0000; din = 8'h00; rd = 1'b0; wr = 1'b0; req = 8'h00;
    ime0 = 1'b0; ack0 = 1'b0; ime1 = 1'b0; ack1 = 1'b0; ime2 = 1'b0; ack2 = 1'b0;

    fork
      mon0();
      mon2();
      begin
        #200000;
        $display("FAIL watchdog_timeout actual=expired required=finished");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset state
    #2;
    chk("rst_irq", {15'd0, irq0}, 16'd0);
    chk("rst_vec", vec0, 16'h0000);
    chk("rst_vec_valid", {15'd0, vv0}, 16'd0);
    chk("rst_pending", {11'd0, pend0}, 16'd0);
    step(); step();
    rst = 1'b1;
    step();

    // ack while idle must not produce a grant
    ack0 = 1'b1; step(); ack0 = 1'b0; step();

    // Defaults: single source 2 through the full handshake
    reg_write(IE_A, 8'h1F);
    ime0 = 1'b1;
    req = 8'h04; step(); req = 8'h00;
    chk("t1_if_set", {11'd0, pend0}, 16'h0004);
    step();
    chk("t1_irq", {15'd0, irq0}, 16'd1);
    q0.push_back(16'h0050);
    ack0 = 1'b1; step(); ack0 = 1'b0;
    chk("t1_vec_valid", {15'd0, vv0}, 16'd1);
    chk("t1_if_cleared", {11'd0, pend0}, 16'h0000);
    chk("t1_irq_grant", {15'd0, irq0}, 16'd0);
    step();
    chk("t1_vec_held", vec0, 16'h0050);

    // Priority: sources 1 and 4 pending; ack held into GRANT is ignored
    reg_write(IF_A, 8'h12);
    step();
    chk("t2_irq", {15'd0, irq0}, 16'd1);
    q0.push_back(16'h0048);
    ack0 = 1'b1; step();
    chk("t2_if_after_first", {11'd0, pend0}, 16'h0010);
    step(); ack0 = 1'b0;
    step();
    chk("t2_irq_again", {15'd0, irq0}, 16'd1);
    q0.push_back(16'h0060);
    ack0 = 1'b1; step(); ack0 = 1'b0;
    chk("t2_if_after_second", {11'd0, pend0}, 16'h0000);
    step();

    // Collision: write 0 to IF on the same edge as a source 3 rising edge
    a = IF_A; din = 8'h00; wr = 1'b1; req = 8'h08;
    step();
    wr = 1'b0; req = 8'h00;
    chk("t3_set_wins", {11'd0, pend0}, 16'h0008);
    step();
    chk("t3_irq", {15'd0, irq0}, 16'd1);
    // Cancel: flag cleared while pending, then ack sees nothing enabled
    reg_write(IF_A, 8'h00);
    q0.push_back(16'h0000);
    ack0 = 1'b1; step(); ack0 = 1'b0;
    chk("t3_cancel_vv", {15'd0, vv0}, 16'd1);
    chk("t3_cancel_if", {11'd0, pend0}, 16'h0000);
    step();

    // Reads and wake with ime low
    ime0 = 1'b0;
    reg_write(IF_A, 8'h01);
    rd = 1'b1; a = IF_A; #1;
    chk("rd_if", {8'd0, dout0}, 16'h00E1);
    chk("sel_if", {15'd0, sel0}, 16'd1);
    a = IE_A; #1;
    chk("rd_ie", {8'd0, dout0}, 16'h001F);
    a = 16'h1234; #1;
    chk("rd_other", {8'd0, dout0}, 16'h0000);
    chk("sel_other", {15'd0, sel0}, 16'd0);
    rd = 1'b0; a = IF_A; #1;
    chk("rd_strobe_low", {8'd0, dout0}, 16'h0000);
    step();
    chk("wake_ime0", {15'd0, wake0}, 16'd1);
    chk("irq_ime0", {15'd0, irq0}, 16'd0);

    // Reset while in GRANT: outputs drop at once and no pulse follows
    ime0 = 1'b1; step();
    chk("t4_irq", {15'd0, irq0}, 16'd1);
    ack0 = 1'b1; step(); ack0 = 1'b0;
    chk("t4_in_grant", {15'd0, vv0}, 16'd1);
    rst = 1'b0; #1;
    chk("t4_rst_vv", {15'd0, vv0}, 16'd0);
    chk("t4_rst_vec", vec0, 16'h0000);
    chk("t4_rst_irq", {15'd0, irq0}, 16'd0);
    chk("t4_rst_wake", {15'd0, wake0}, 16'd0);
    req = 8'h04;
    step(); step();
    rst = 1'b1;
    step();
    chk("t4_held_req_sets_once", {11'd0, pend0}, 16'h0004);
    reg_write(IF_A, 8'h00);
    step();
    chk("t4_held_req_no_reset", {11'd0, pend0}, 16'h0000);
    req = 8'h00; step();

    // Edge vs level on dut1 (source 0 level, source 1 edge)
    req = 8'h03; step();
    reg_write(IF_A, 8'h00);
    chk("t5_level_resets", {11'd0, pend1}, 16'h0001);
    chk("t5_edge_default", {11'd0, pend0}, 16'h0000);
    req = 8'h00;
    reg_write(IF_A, 8'h00);
    chk("t5_level_released", {11'd0, pend1}, 16'h0000);

    // 8-source build with wrapping vector
    ime0 = 1'b0;
    reg_write(IE_A, 8'hFF);
    ime2 = 1'b1;
    req = 8'h08; step(); req = 8'h00;
    step();
    chk("t6_irq2", {15'd0, irq2}, 16'd1);
    chk("t6_wake0", {15'd0, wake0}, 16'd1);
    chk("t6_irq0_masked", {15'd0, irq0}, 16'd0);
    q2.push_back(16'h0004);
    ack2 = 1'b1; step(); ack2 = 1'b0;
    chk("t6_if2_cleared", {8'd0, pend2}, 16'h0000);
    step(); step(); step();

    chk("q0_drained", 16'(q0.size()), 16'd0);
    chk("q2_drained", 16'(q2.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
